mem_arbiter: RTL and testbench
==============================

MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_MAX, default 4, giving the maximum consecutive MA grants while IF waits.
REQ-002 The block SHALL have port clk  input  1  single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port reset  input  1  asynchronous, active-low reset (0 = reset).
REQ-004 The block SHALL have ports if_req  input  1  fetch request; if_addr  input  32  fetch byte address.
REQ-005 The block SHALL have ports if_gnt  output  1  fetch grant; if_rvalid  output  1  fetch data valid; if_rdata  output  32  fetch data.
REQ-006 The block SHALL have ports ma_req  input  1  data request; ma_we  input  1  1 = store; ma_addr  input  32  data address; ma_wdata  input  32  store data; ma_ctrl  input  3  funct3 size code.
REQ-007 The block SHALL have ports ma_gnt  output  1  data grant; ma_rvalid  output  1  load data or store ack; ma_rdata  output  32  load data; ma_err  output  1  misalignment error pulse.
REQ-008 The block SHALL have ports mem_req, mem_we  output  1; mem_addr, mem_wdata  output  32; mem_ctrl  output  3; all driving the shared single-port memory.
REQ-009 The block SHALL have ports mem_ready  input  1  memory done this cycle; mem_rdata  input  32  memory read data, valid when mem_ready=1.

Function
REQ-010 The FSM SHALL have states IDLE, BUSY_IF and BUSY_MA.
REQ-011 In IDLE, if_gnt/ma_gnt SHALL be combinational: ma_gnt=ma_req&~if_win, if_gnt=if_req&(if_win|~ma_req), where if_win=(starve_cnt==STARVE_MAX).
REQ-012 Outside IDLE, both grants SHALL be 0; requests are ignored until the FSM returns to IDLE.
REQ-013 On the edge ending a grant cycle, the block SHALL capture the winner's address, we, wdata and ctrl (IF: we=0, ctrl=3'b010), then enter BUSY_IF or BUSY_MA.
REQ-014 Requesters SHALL hold req and payload stable until the grant; after the grant they may change them freely.
REQ-015 In BUSY_*, mem_req SHALL be 1 and the mem_* outputs SHALL show the captured values unchanged until the mem_ready cycle.
REQ-016 In IDLE, mem_req and mem_we SHALL be 0.
REQ-017 On a BUSY_* cycle with mem_ready=1, the FSM SHALL return to IDLE, and the owner's rvalid SHALL be 1 for exactly the next cycle, with rdata registered from mem_rdata.
REQ-018 For stores, ma_rvalid SHALL act as the store ack, and ma_rdata SHALL be 0.
REQ-019 The minimum transaction SHALL be: grant cycle N, mem_req in cycle N+1, rvalid in cycle N+2 when mem_ready=1 in cycle N+1.
REQ-020 A new grant SHALL be possible in the same cycle that rvalid is asserted, because that cycle is IDLE.
REQ-021 Misalignment SHALL mean: ma_ctrl[1:0]=2'b10 with ma_addr[1:0]!=0, or ma_ctrl[1:0]=2'b01 with ma_addr[0]=1.
REQ-022 A misaligned MA winner SHALL still get ma_gnt, but the FSM stays in IDLE, no mem_req is issued, and ma_err=1 for exactly the next cycle with no ma_rvalid.
REQ-023 starve_cnt SHALL be 0 to STARVE_MAX wide enough, and SHALL increment, saturating, on each ma_gnt cycle with if_req=1.
REQ-024 starve_cnt SHALL clear on an if_gnt, and SHALL be unchanged on an ma_gnt with if_req=0.
REQ-025 If both requests are high and starve_cnt<STARVE_MAX, MA SHALL win; at STARVE_MAX, IF SHALL win.
REQ-026 mem_ready during IDLE SHALL be ignored.
REQ-027 mem_ready SHALL be able to stay low indefinitely, with no timeout.
REQ-028 Misaligned grants SHALL count toward starve_cnt as ma_gnt.

Reset
REQ-029 When reset=0 (asynchronously), state SHALL be IDLE, starve_cnt=0, and all rvalid, ma_err, mem_req and mem_we outputs SHALL be 0; all captured and rdata registers SHALL be 0.
REQ-030 A reset during BUSY_* SHALL abort the transaction: mem_req drops immediately, and no rvalid or ma_err is issued afterward.
REQ-031 The first grant after reset deasserts SHALL be possible in the first clk cycle with reset=1.

Verification
REQ-032 Only if_req=1 with if_addr=0x100, memory ready after 1 cycle returning 0x00500093 -> if_gnt at N, mem_req/mem_addr=0x100 at N+1, if_rvalid with if_rdata=0x00500093 at N+2.
REQ-033 Both requests high, ma_we=1, ma_addr=0x2000, ma_wdata=0xDEADBEEF -> ma_gnt, mem_we=1 with matching address and data, ma_rvalid with ma_rdata=0, if_gnt=0 throughout.
REQ-034 if_req held high and ma_req held high for 6 transactions, STARVE_MAX=4 -> grant order MA,MA,MA,MA,IF,MA.
REQ-035 ma_ctrl=3'b010 with ma_addr=0x2002 -> ma_gnt, no mem_req, ma_err pulse one cycle; then ma_ctrl=3'b001 with addr 0x2001 -> error; 3'b000 with addr 0x2001 -> normal access.
REQ-036 mem_ready held low 10 cycles in BUSY_MA -> mem_* stable and no grants while waiting, with if_req=1; then mem_ready=1 -> ma_rvalid, then if_gnt in the same cycle.
REQ-037 reset=0 in BUSY_IF mid-wait -> mem_req=0 immediately, no if_rvalid; after release, if_req=1 -> if_gnt in the first cycle.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-requester (fetch / data) arbiter in front of a single-port memory.
// Data side wins by default; fetch is forced through after STARVE_MAX data grants.
module mem_arbiter #(
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_gnt,
    output logic        if_rvalid,
    output logic [31:0] if_rdata,
    input  logic        ma_req,
    input  logic        ma_we,
    input  logic [31:0] ma_addr,
    input  logic [31:0] ma_wdata,
    input  logic [2:0]  ma_ctrl,
    output logic        ma_gnt,
    output logic        ma_rvalid,
    output logic [31:0] ma_rdata,
    output logic        ma_err,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [2:0]  mem_ctrl,
    input  logic        mem_ready,
    input  logic [31:0] mem_rdata
);
    localparam int CW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);

    typedef enum logic [1:0] {IDLE, BUSY_IF, BUSY_MA} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] starve_cnt;
    logic          if_win, ma_misal;
    logic [31:0]   cap_addr, cap_wdata;
    logic          cap_we;
    logic [2:0]    cap_ctrl;

    assign if_win   = (starve_cnt == CW'(STARVE_MAX));
    assign ma_misal = ((ma_ctrl[1:0] == 2'b10) && (ma_addr[1:0] != 2'b00)) ||
                      ((ma_ctrl[1:0] == 2'b01) && ma_addr[0]);

    always_comb begin
        state_nxt = state;
        if_gnt    = 1'b0;
        ma_gnt    = 1'b0;
        case (state)
            IDLE: begin
                ma_gnt = ma_req & ~if_win;
                if_gnt = if_req & (if_win | ~ma_req);
                // a misaligned data grant is answered locally; the memory is never touched
                if (ma_gnt && !ma_misal) state_nxt = BUSY_MA;
                else if (if_gnt)         state_nxt = BUSY_IF;
            end
            BUSY_IF, BUSY_MA: begin
                if (mem_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            starve_cnt <= '0;
            cap_addr   <= '0;
            cap_wdata  <= '0;
            cap_we     <= 1'b0;
            cap_ctrl   <= '0;
            if_rvalid  <= 1'b0;
            if_rdata   <= '0;
            ma_rvalid  <= 1'b0;
            ma_rdata   <= '0;
            ma_err     <= 1'b0;
        end else begin
            state     <= state_nxt;
            if_rvalid <= (state == BUSY_IF) && mem_ready;
            ma_rvalid <= (state == BUSY_MA) && mem_ready;
            ma_err    <= ma_gnt && ma_misal;

            if ((state == BUSY_IF) && mem_ready) if_rdata <= mem_rdata;
            if ((state == BUSY_MA) && mem_ready) ma_rdata <= cap_we ? 32'h0 : mem_rdata;

            if (if_gnt) starve_cnt <= '0;
            else if (ma_gnt && if_req && !if_win) starve_cnt <= starve_cnt + 1'b1;

            if (if_gnt) begin
                cap_addr  <= if_addr;
                cap_we    <= 1'b0;
                cap_wdata <= '0;
                cap_ctrl  <= 3'b010;
            end else if (ma_gnt && !ma_misal) begin
                cap_addr  <= ma_addr;
                cap_we    <= ma_we;
                cap_wdata <= ma_wdata;
                cap_ctrl  <= ma_ctrl;
            end
        end
    end

    assign mem_req   = (state != IDLE);
    assign mem_we    = mem_req & cap_we;
    assign mem_addr  = cap_addr;
    assign mem_wdata = cap_wdata;
    assign mem_ctrl  = cap_ctrl;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against a transaction-level model.
module tb_mem_arbiter;
    localparam int SM = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        if_req = 1'b0;
    logic [31:0] if_addr = '0;
    logic        if_gnt, if_rvalid;
    logic [31:0] if_rdata;
    logic        ma_req = 1'b0, ma_we = 1'b0;
    logic [31:0] ma_addr = '0, ma_wdata = '0;
    logic [2:0]  ma_ctrl = 3'b010;
    logic        ma_gnt, ma_rvalid, ma_err;
    logic [31:0] ma_rdata;
    logic        mem_req, mem_we;
    logic [31:0] mem_addr, mem_wdata;
    logic [2:0]  mem_ctrl;
    logic        mem_ready = 1'b0;
    logic [31:0] mem_rdata = '0;

    mem_arbiter #(.STARVE_MAX(SM)) dut (
        .clk(clk), .reset(reset),
        .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
        .if_rvalid(if_rvalid), .if_rdata(if_rdata),
        .ma_req(ma_req), .ma_we(ma_we), .ma_addr(ma_addr), .ma_wdata(ma_wdata),
        .ma_ctrl(ma_ctrl), .ma_gnt(ma_gnt), .ma_rvalid(ma_rvalid),
        .ma_rdata(ma_rdata), .ma_err(ma_err),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ctrl(mem_ctrl),
        .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // model: who owns the memory (0 none, 1 fetch, 2 data) and the transaction in flight
    int          m_owner;
    int          m_starve;
    logic [31:0] m_addr, m_wdata;
    logic        m_we;
    logic [2:0]  m_ctrl;
    logic        m_if_rv, m_ma_rv, m_err;
    logic [31:0] m_if_rd, m_ma_rd;
    bit          last_if_gnt, last_ma_gnt;

    logic        s_if_gnt, s_ma_gnt, s_mem_req, s_mem_we, s_if_rv, s_ma_rv, s_ma_err;
    logic [31:0] s_mem_addr, s_mem_wdata, s_if_rd, s_ma_rd;
    logic [2:0]  s_mem_ctrl;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit misaligned(input logic [2:0] c, input logic [31:0] a);
        int sz;
        sz = 1 << c[1:0];
        if (c[1:0] == 2'd1 || c[1:0] == 2'd2) return (a % sz) != 0;
        return 1'b0;
    endfunction

    task automatic model_reset();
        m_owner = 0; m_starve = 0;
        m_addr = '0; m_wdata = '0; m_we = 1'b0; m_ctrl = '0;
        m_if_rv = 1'b0; m_ma_rv = 1'b0; m_err = 1'b0;
        m_if_rd = '0; m_ma_rd = '0;
    endtask

    // one clock cycle: sample just after the falling edge, compare, advance the model
    task automatic cyc();
        bit idle, win, e_if, e_ma;
        #1;
        if (!reset) model_reset();
        s_if_gnt = if_gnt; s_ma_gnt = ma_gnt; s_mem_req = mem_req; s_mem_we = mem_we;
        s_if_rv = if_rvalid; s_ma_rv = ma_rvalid; s_ma_err = ma_err;
        s_mem_addr = mem_addr; s_mem_wdata = mem_wdata; s_mem_ctrl = mem_ctrl;
        s_if_rd = if_rdata; s_ma_rd = ma_rdata;

        idle = (m_owner == 0);
        win  = (m_starve == SM);
        e_ma = idle && ma_req && !win;
        e_if = idle && if_req && (win || !ma_req);

        chk("if_gnt", if_gnt, e_if);
        chk("ma_gnt", ma_gnt, e_ma);
        chk("mem_req", mem_req, !idle);
        chk("mem_we", mem_we, !idle && m_we);
        if (!idle) begin
            chk("mem_addr", mem_addr, m_addr);
            chk("mem_ctrl", mem_ctrl, m_ctrl);
            if (m_we) chk("mem_wdata", mem_wdata, m_wdata);
        end
        chk("if_rvalid", if_rvalid, m_if_rv);
        chk("ma_rvalid", ma_rvalid, m_ma_rv);
        chk("ma_err", ma_err, m_err);
        if (m_if_rv) chk("if_rdata", if_rdata, m_if_rd);
        if (m_ma_rv) chk("ma_rdata", ma_rdata, m_ma_rd);

        if (reset) begin
            m_if_rv = 1'b0; m_ma_rv = 1'b0; m_err = 1'b0;
            if (!idle && mem_ready) begin
                if (m_owner == 1) begin m_if_rv = 1'b1; m_if_rd = mem_rdata; end
                else begin m_ma_rv = 1'b1; m_ma_rd = m_we ? 32'h0 : mem_rdata; end
                m_owner = 0;
            end
            if (e_ma) begin
                if (if_req && m_starve < SM) m_starve++;
                if (misaligned(ma_ctrl, ma_addr)) m_err = 1'b1;
                else begin
                    m_owner = 2; m_addr = ma_addr; m_we = ma_we;
                    m_wdata = ma_wdata; m_ctrl = ma_ctrl;
                end
            end
            if (e_if) begin
                m_starve = 0; m_owner = 1; m_addr = if_addr;
                m_we = 1'b0; m_ctrl = 3'b010;
            end
        end
        last_if_gnt = e_if;
        last_ma_gnt = e_ma;
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [5:0] ord;
        int n;
        logic [2:0] ctrl_tab [5];
        ctrl_tab[0] = 3'b000; ctrl_tab[1] = 3'b001; ctrl_tab[2] = 3'b010;
        ctrl_tab[3] = 3'b100; ctrl_tab[4] = 3'b101;
        model_reset();
        @(negedge clk);

        // reset state
        cyc(); cyc();
        chk("rst if_rvalid", s_if_rv, 0);
        chk("rst mem_req", s_mem_req, 0);
        chk("rst ma_err", s_ma_err, 0);
        chk("rst if_rdata", s_if_rd, 0);
        chk("rst ma_rdata", s_ma_rd, 0);

        // fetch-only transaction, grant in first cycle out of reset
        reset = 1; if_req = 1; if_addr = 32'h100;
        cyc(); chk("t1 if_gnt", s_if_gnt, 1);
        if_req = 0; mem_ready = 1; mem_rdata = 32'h00500093;
        cyc(); chk("t1 mem_req", s_mem_req, 1); chk("t1 mem_addr", s_mem_addr, 32'h100);
        mem_ready = 0;
        cyc(); chk("t1 if_rvalid", s_if_rv, 1); chk("t1 if_rdata", s_if_rd, 32'h00500093);

        // store beats fetch
        if_req = 1; ma_req = 1; ma_we = 1; ma_addr = 32'h2000; ma_wdata = 32'hDEADBEEF; ma_ctrl = 3'b010;
        cyc(); chk("t2 ma_gnt", s_ma_gnt, 1); chk("t2 if_gnt", s_if_gnt, 0);
        if_req = 0; ma_req = 0; mem_ready = 1;
        cyc(); chk("t2 mem_we", s_mem_we, 1); chk("t2 mem_addr", s_mem_addr, 32'h2000);
        chk("t2 mem_wdata", s_mem_wdata, 32'hDEADBEEF); chk("t2 if_gnt busy", s_if_gnt, 0);
        mem_ready = 0;
        cyc(); chk("t2 ma_rvalid", s_ma_rv, 1); chk("t2 ma_rdata", s_ma_rd, 0);

        // starvation limit: grant order with both held high
        reset = 0; cyc(); reset = 1;
        if_req = 1; ma_req = 1; ma_we = 0; ma_addr = 32'h2000; ma_ctrl = 3'b010; mem_ready = 1;
        ord = '0; n = 0;
        for (int i = 0; i < 14; i++) begin
            cyc();
            if ((s_ma_gnt || s_if_gnt) && n < 6) begin ord[n] = s_if_gnt; n++; end
        end
        chk("t3 grant order", ord, 6'b010000);
        chk("t3 grant count", n, 6);

        // misalignment
        if_req = 0; ma_req = 0; cyc(); cyc(); cyc();
        ma_req = 1; ma_ctrl = 3'b010; ma_addr = 32'h2002; mem_ready = 0;
        cyc(); chk("t4 gnt word", s_ma_gnt, 1);
        ma_req = 0;
        cyc(); chk("t4 no mem_req", s_mem_req, 0); chk("t4 err", s_ma_err, 1); chk("t4 no rvalid", s_ma_rv, 0);
        cyc(); chk("t4 err one cycle", s_ma_err, 0);
        ma_req = 1; ma_ctrl = 3'b001; ma_addr = 32'h2001;
        cyc(); chk("t4 gnt half", s_ma_gnt, 1);
        ma_req = 0;
        cyc(); chk("t4 err half", s_ma_err, 1); chk("t4 no mem_req half", s_mem_req, 0);
        ma_req = 1; ma_ctrl = 3'b000;
        cyc(); chk("t4 gnt byte", s_ma_gnt, 1);
        ma_req = 0; mem_ready = 1;
        cyc(); chk("t4 byte mem_req", s_mem_req, 1); chk("t4 byte no err", s_ma_err, 0);
        chk("t4 byte addr", s_mem_addr, 32'h2001); chk("t4 byte ctrl", s_mem_ctrl, 0);
        cyc(); chk("t4 byte rvalid", s_ma_rv, 1);

        // long memory stall with fetch waiting
        reset = 0; cyc(); reset = 1;
        ma_req = 1; if_req = 1; if_addr = 32'h180; ma_addr = 32'h3000; ma_ctrl = 3'b010; ma_we = 0; mem_ready = 0;
        cyc(); chk("t5 ma_gnt", s_ma_gnt, 1);
        ma_req = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk("t5 stall mem_req", s_mem_req, 1); chk("t5 stall addr", s_mem_addr, 32'h3000);
            chk("t5 stall if_gnt", s_if_gnt, 0);
        end
        mem_ready = 1; cyc(); mem_ready = 0;
        cyc(); chk("t5 ma_rvalid", s_ma_rv, 1); chk("t5 if_gnt same cycle", s_if_gnt, 1);

        // reset aborts a fetch in flight
        if_req = 0;
        cyc(); cyc(); chk("t6 busy", s_mem_req, 1);
        reset = 0;
        cyc(); chk("t6 abort mem_req", s_mem_req, 0);
        mem_ready = 1; cyc();
        reset = 1; if_req = 1; if_addr = 32'h200; mem_ready = 0;
        cyc(); chk("t6 if_gnt after reset", s_if_gnt, 1); chk("t6 no rvalid", s_if_rv, 0);

        // randomized traffic; requesters hold request and payload until granted
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) != 0);
            if (!(if_req && !last_if_gnt)) begin
                if_req = ($urandom_range(0, 2) != 0);
                if_addr = $urandom;
            end
            if (!(ma_req && !last_ma_gnt)) begin
                ma_req = $urandom_range(0, 1);
                ma_we = $urandom_range(0, 1);
                ma_addr = $urandom;
                ma_wdata = $urandom;
                ma_ctrl = ctrl_tab[$urandom_range(0, 4)];
            end
            mem_ready = ($urandom_range(0, 2) != 0);
            mem_rdata = $urandom;
            cyc();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
